// File: rtl/mmio_uart_tx_if.sv
// Store-side bus between the single-cycle core and the MMIO UART transmitter.
// The core drives the store strobe, address and data; the peripheral answers with its select and read data.
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        sel;
  logic [31:0] ReadData;

  modport master (
    output MemWrite,
    output ALUResult,
    output WriteData,
    input  sel,
    input  ReadData
  );

  modport slave (
    input  MemWrite,
    input  ALUResult,
    input  WriteData,
    output sel,
    output ReadData
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL window, TX FIFO, serialiser FSM.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_ZERO = BW'(0);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            en_q, en_d;

  logic            sel_s;
  logic            wr_s;
  logic [1:0]      off_s;
  logic            push_req_s;
  logic            push_s;
  logic            pop_s;
  logic            ovf_set_s;
  logic            w1c_s;
  logic            ctrl_wr_s;
  logic            full_s;
  logic            empty_s;
  logic            can_pop_s;
  logic [31:0]     rdata_s;

  wire unused_bits_s = ^{bus.WriteData[31:8], bus.ALUResult[1:0]};

  // Address decode and register write strobes.
  always_comb begin
    sel_s      = (bus.ALUResult[31:4] == BASE_ADDR[31:4]);
    off_s      = bus.ALUResult[3:2];
    wr_s       = bus.MemWrite & sel_s;
    push_req_s = wr_s && (off_s == 2'd0);
    w1c_s      = wr_s && (off_s == 2'd1) && bus.WriteData[3];
    ctrl_wr_s  = wr_s && (off_s == 2'd2);
    full_s     = (count_q == CNT_FULL);
    empty_s    = (count_q == CNT_ZERO);
    can_pop_s  = en_q && !empty_s;
  end

  // FSM state register and serialiser datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= BAUD_ZERO;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; a pop loads the shift register on the same edge it leaves IDLE or STOP.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_pop_s) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rd_q];
          baud_d  = BAUD_ZERO;
          bit_d   = 3'd0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = BAUD_ZERO;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = BAUD_ZERO;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = BAUD_ZERO;
          bit_d  = 3'd0;
          if (can_pop_s) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rd_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = BAUD_ZERO;
        bit_d   = 3'd0;
      end
    endcase
  end

  // Line level follows the state being entered, so tx changes on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO, overflow flag and enable next values; a pop in the same cycle frees room for a push when full.
  always_comb begin
    push_s    = push_req_s && (!full_s || pop_s);
    ovf_set_s = push_req_s && full_s && !pop_s;
    mem_d     = mem_q;
    if (push_s) begin
      mem_d[wr_q] = bus.WriteData[7:0];
    end else begin
      mem_d[wr_q] = mem_q[wr_q];
    end
    wr_d = push_s ? (wr_q + PTR_ONE) : wr_q;
    rd_d = pop_s  ? (rd_q + PTR_ONE) : rd_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (w1c_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (ctrl_wr_s) begin
      en_d = bus.WriteData[0];
    end else begin
      en_d = en_q;
    end
  end

  // FIFO storage and control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_q    <= PTR_ZERO;
      rd_q    <= PTR_ZERO;
      count_q <= CNT_ZERO;
      ovf_q   <= 1'b0;
      en_q    <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      en_q    <= en_d;
    end
  end

  // Combinational register read path, zero outside the window.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (sel_s) begin
      case (off_s)
        2'd1: begin
          rdata_s[0]      = full_s;
          rdata_s[1]      = empty_s;
          rdata_s[2]      = (state_q != S_IDLE);
          rdata_s[3]      = ovf_q;
          rdata_s[8+AW:8] = count_q;
        end
        2'd2:    rdata_s[0] = en_q;
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign bus.sel      = sel_s;
  assign bus.ReadData = rdata_s;
  assign tx           = tx_q;
  assign busy         = (state_q != S_IDLE) || !empty_s;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench: directed scenarios plus randomized bursts, judged by a line decoder and a byte-queue model.
module tb_mmio_uart_tx;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam int          FRAME = 10 * CPB;
  localparam int          LOGN  = 16384;
  localparam logic [31:0] A_TX  = 32'h0000_1000;
  localparam logic [31:0] A_ST  = 32'h0000_1004;
  localparam logic [31:0] A_CT  = 32'h0000_1008;
  localparam logic [31:0] A_RS  = 32'h0000_100C;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic busy;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_1000),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int glitches = 0;
  logic        tx_log   [LOGN];
  logic        busy_log [LOGN];
  logic [7:0]  rx_q[$];
  int          rx_start[$];
  logic [7:0]  exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Line/busy trace, one sample per cycle just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cyc < LOGN) begin
        tx_log[cyc]   = tx;
        busy_log[cyc] = busy;
      end
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, output int wc);
    @(negedge clk);
    bus.MemWrite  = 1'b1;
    bus.ALUResult = addr;
    bus.WriteData = data;
    @(posedge clk);
    wc = cyc;
    #1;
    bus.MemWrite  = 1'b0;
    bus.ALUResult = 32'h0;
    bus.WriteData = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic s);
    @(negedge clk);
    bus.MemWrite  = 1'b0;
    bus.ALUResult = addr;
    #1;
    data = bus.ReadData;
    s    = bus.sel;
    bus.ALUResult = 32'h0;
  endtask

  // UART receiver over the trace: every bit must hold for CPB samples, start low, stop high.
  task automatic decode(input int from, input int upto);
    int i;
    logic [9:0] bits;
    i = from;
    while (i + FRAME <= upto) begin
      if (tx_log[i] === 1'b0) begin
        for (int b = 0; b < 10; b++) begin
          bits[b] = tx_log[i + b*CPB + CPB/2];
          for (int c = 0; c < CPB; c++) begin
            if (tx_log[i + b*CPB + c] !== bits[b]) glitches++;
          end
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) glitches++;
        rx_q.push_back(bits[8:1]);
        rx_start.push_back(i);
        i += FRAME;
      end else begin
        if (tx_log[i] !== 1'b1) glitches++;
        i++;
      end
    end
  endtask

  task automatic check_rx(input string tag, input int mark);
    rx_q.delete();
    rx_start.delete();
    glitches = 0;
    decode(mark, (cyc < LOGN) ? cyc : LOGN);
    check_val({tag, "_glitch"}, glitches, 0);
    check_val({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < rx_q.size(); j++) begin
      check_val($sformatf("%s_byte%0d", tag, j), {24'h0, rx_q[j]}, {24'h0, exp_q[j]});
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_drain"}, {31'h0, (n < 3000)}, 32'h1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int          wc, w1, w2, w0, w77, mark, n, cnt;
    logic [31:0] rd, addr, expst;
    logic        s;
    logic [7:0]  b;

    reset         = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.ALUResult = 32'h0;
    bus.WriteData = 32'h0;
    repeat (3) @(negedge clk);
    check_val("rst_tx", {31'h0, tx}, 32'h1);
    check_val("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;

    // Register map and out-of-window accesses.
    bus_read(A_ST, rd, s);
    check_val("t5_status", rd, 32'h0000_0002);
    check_val("t5_sel_in", {31'h0, s}, 32'h1);
    bus_read(A_CT, rd, s);
    check_val("t5_ctrl", rd, 32'h0000_0001);
    bus_read(A_TX, rd, s);
    check_val("t5_txdata_rd", rd, 32'h0);
    bus_read(A_RS, rd, s);
    check_val("t5_rsvd_rd", rd, 32'h0);
    bus_read(32'h0000_2000, rd, s);
    check_val("t5_out_data", rd, 32'h0);
    check_val("t5_out_sel", {31'h0, s}, 32'h0);
    bus_write(32'h0000_2000, 32'h0000_0041, wc);
    bus_read(A_ST, rd, s);
    check_val("t5_out_write", rd, 32'h0000_0002);

    // Single frame, exact timing.
    mark = cyc;
    exp_q = '{8'h55};
    bus_write(A_TX, 32'h55, wc);
    check_val("t1_tx_hold", {31'h0, tx}, 32'h1);
    wait_idle("t1");
    check_rx("t1", mark);
    if (rx_start.size() > 0) check_val("t1_start", rx_start[0], wc + 1);
    check_val("t1_busy_stop", {31'h0, busy_log[wc + FRAME]}, 32'h1);
    check_val("t1_busy_idle", {31'h0, busy_log[wc + FRAME + 1]}, 32'h0);
    check_val("t1_tx_idle", {31'h0, tx_log[wc + FRAME + 1]}, 32'h1);

    // Back-to-back frames without an idle gap.
    mark = cyc;
    exp_q = '{8'hA3, 8'h0F};
    bus_write(A_TX, 32'hA3, w1);
    bus_write(A_TX, 32'h0F, w2);
    wait_idle("t2");
    check_rx("t2", mark);
    if (rx_start.size() > 1) begin
      check_val("t2_start", rx_start[0], w1 + 1);
      check_val("t2_contig", rx_start[1] - rx_start[0], FRAME);
    end

    // Disabled fill with overflow, W1C, then drain.
    mark = cyc;
    bus_write(A_CT, 32'h0, wc);
    for (int k = 1; k <= 9; k++) bus_write(A_TX, k, wc);
    bus_read(A_ST, rd, s);
    check_val("t3_full_status", rd, 32'h0000_0809);
    bus_read(A_CT, rd, s);
    check_val("t3_ctrl_off", rd, 32'h0);
    exp_q = {};
    check_rx("t3_quiet", mark);
    bus_write(A_ST, 32'h8, wc);
    bus_read(A_ST, rd, s);
    check_val("t3_w1c", rd, 32'h0000_0801);
    mark = cyc;
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    bus_write(A_CT, 32'h1, wc);
    wait_idle("t3");
    check_rx("t3", mark);

    // Push into a full FIFO on the same edge the STOP state pops.
    mark = cyc;
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h77};
    bus_write(A_TX, 32'h10, w0);
    for (int k = 1; k <= 8; k++) bus_write(A_TX, 32'h10 + k, wc);
    while (cyc < w0 + FRAME) @(negedge clk);
    bus_write(A_TX, 32'h77, w77);
    check_val("t4_push_edge", w77, w0 + FRAME + 1);
    bus_read(A_ST, rd, s);
    check_val("t4_status", rd, 32'h0000_0805);
    wait_idle("t4");
    check_rx("t4", mark);

    // Asynchronous reset in the middle of DATA.
    bus_write(A_TX, 32'h5A, wc);
    bus_write(A_TX, 32'h11, w1);
    bus_write(A_TX, 32'h22, w1);
    while (cyc < wc + 1 + 3*CPB) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("t6_tx_async", {31'h0, tx}, 32'h1);
    check_val("t6_busy_async", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_ST, rd, s);
    check_val("t6_status", rd, 32'h0000_0002);
    mark = cyc;
    repeat (100) @(negedge clk);
    exp_q = {};
    check_rx("t6_quiet", mark);

    // Randomized bursts against the byte-queue model.
    for (int it = 0; it < 8; it++) begin
      addr = $urandom;
      if (addr[31:4] == 28'h0000100) addr[20] = ~addr[20];
      bus_read(addr, rd, s);
      check_val($sformatf("r%0d_out_sel", it), {31'h0, s}, 32'h0);
      check_val($sformatf("r%0d_out_data", it), rd, 32'h0);
      exp_q = {};
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 11);
        bus_write(A_CT, 32'h0, wc);
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom);
          if (k < DEPTH) exp_q.push_back(b);
          bus_write(A_TX, {24'h0, b}, wc);
        end
        cnt   = (n < DEPTH) ? n : DEPTH;
        expst = (cnt << 8) | ((n > DEPTH) ? 32'h8 : 32'h0) | ((cnt == DEPTH) ? 32'h1 : 32'h0);
        bus_read(A_ST, rd, s);
        check_val($sformatf("r%0d_status", it), rd, expst);
        bus_write(A_ST, 32'h8, wc);
        mark = cyc;
        bus_write(A_CT, 32'h1, wc);
      end else begin
        n = $urandom_range(1, DEPTH);
        mark = cyc;
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom);
          exp_q.push_back(b);
          bus_write(A_TX, {24'h0, b}, wc);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      wait_idle($sformatf("r%0d", it));
      check_rx($sformatf("r%0d", it), mark);
      bus_read(A_ST, rd, s);
      check_val($sformatf("r%0d_final", it), rd, 32'h0000_0002);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
